// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state encoding, defaults and line-address helper
package cache_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MISS_CRIT = 3'd1,
      MISS_REST = 3'd2,
      LINE_WR   = 3'd3,
      SB_DRAIN  = 3'd4,
      WT_WAIT   = 3'd5
   } state_t;

   localparam int OFFS_W_DEF  = 3;
   localparam int INDEX_W_DEF = 7;

   function automatic logic [63:0] line_mask(input logic [63:0] addr, input int offs_w);
      return addr & ~((64'd1 << offs_w) - 64'd1);
   endfunction

endpackage

// File: rtl/cache_sb_counter.sv
// rtl/cache_sb_counter.sv - store-buffer occupancy counter with full/empty flags
module cache_sb_counter #(
   parameter int SB_DEPTH = 4,
   parameter int CW       = $clog2(SB_DEPTH + 1)
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          push,
   input  logic          pop,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic do_push;
   logic do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(SB_DEPTH));
   // A pop frees the slot a simultaneous push needs, so a full buffer may still take both
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         count <= '0;
      end else if (do_push && !do_pop) begin
         count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/cache_ctrl_nb.sv
// rtl/cache_ctrl_nb.sv - non-blocking cache controller with critical-word restart and store buffer
module cache_ctrl_nb
   import cache_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int OFFS_W   = OFFS_W_DEF,
   parameter int INDEX_W  = INDEX_W_DEF,
   parameter bit WT_MODE  = 1'b0,
   parameter int SB_DEPTH = 4
) (
   input  logic                             Clk,
   input  logic                             Rst_n,
   input  logic                             En,
   input  logic                             RW,
   input  logic [ADDR_W-1:0]                WordAddress,
   output logic                             Stall,
   input  logic                             C_Miss,
   input  logic                             C_Dirty,
   output logic                             R_Enable,
   output logic                             W_Enable,
   output logic                             WriteType,
   output logic                             Merge,
   output logic                             FromStoreBuffer,
   output logic                             CrtWord,
   output logic                             LF_Start,
   output logic [ADDR_W-1:0]                LF_LineAddr,
   input  logic                             LF_FirstWord,
   input  logic                             LF_Done,
   output logic                             LW_Start,
   input  logic                             LW_Done,
   output logic                             WT_Start,
   input  logic                             WT_Done,
   output logic                             SB_Push,
   output logic                             SB_Pop,
   output logic [$clog2(SB_DEPTH+1)-1:0]    SB_Count
);

   localparam int CW = $clog2(SB_DEPTH + 1);

   if (OFFS_W + INDEX_W > ADDR_W || SB_DEPTH < 2) begin : g_param_check
      $error("cache_ctrl_nb: inconsistent OFFS_W/INDEX_W/ADDR_W/SB_DEPTH");
   end

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   lf_addr_q;
   logic [ADDR_W-1:0]   req_line;
   logic                lw_pend_q, lf_done_q;
   logic                lf_start_q, lw_start_q;
   logic                start_miss, same_line;
   logic                sb_full, sb_empty;

   assign req_line    = ADDR_W'(line_mask(64'(WordAddress), OFFS_W));
   assign same_line   = (req_line == lf_addr_q);
   assign LF_Start    = lf_start_q;
   assign LW_Start    = lw_start_q;
   assign LF_LineAddr = lf_addr_q;

   cache_sb_counter #(.SB_DEPTH(SB_DEPTH), .CW(CW)) u_sb_counter (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .push  (SB_Push),
      .pop   (SB_Pop),
      .count (SB_Count),
      .full  (sb_full),
      .empty (sb_empty)
   );

   always_comb begin
      state_d         = state_q;
      Stall           = 1'b0;
      R_Enable        = 1'b0;
      W_Enable        = 1'b0;
      WriteType       = 1'b0;
      Merge           = 1'b0;
      FromStoreBuffer = 1'b0;
      CrtWord         = 1'b0;
      WT_Start        = 1'b0;
      SB_Push         = 1'b0;
      SB_Pop          = 1'b0;
      start_miss      = 1'b0;
      case (state_q)
         IDLE: begin
            if (En) begin
               if (!C_Miss && !RW) begin
                  R_Enable = 1'b1;
               end else if (!C_Miss && !WT_MODE) begin
                  W_Enable = 1'b1;
               end else if (RW && WT_MODE) begin
                  // Write-through: hits also update the array; misses do not allocate
                  W_Enable = !C_Miss;
                  WT_Start = 1'b1;
                  Stall    = 1'b1;
                  state_d  = WT_WAIT;
               end else begin
                  Stall      = 1'b1;
                  start_miss = 1'b1;
                  state_d    = MISS_CRIT;
               end
            end
         end
         MISS_CRIT: begin
            Stall = 1'b1;
            if (LF_FirstWord || LF_Done) begin
               Stall   = 1'b0;
               SB_Push = En && RW;
               CrtWord = En && !RW;
               state_d = MISS_REST;
            end
         end
         MISS_REST: begin
            if (En) begin
               if (same_line) begin
                  if (RW && !sb_full) SB_Push = 1'b1;
                  else                Stall   = 1'b1;
               end else if (C_Miss)  Stall    = 1'b1;
               else if (!RW)         R_Enable = 1'b1;
               else if (!WT_MODE)    W_Enable = 1'b1;
               else                  Stall    = 1'b1;
            end
            if (lf_done_q && !lw_pend_q) state_d = LINE_WR;
         end
         LINE_WR: begin
            Stall     = 1'b1;
            WriteType = 1'b1;
            W_Enable  = 1'b1;
            Merge     = !sb_empty;
            state_d   = sb_empty ? IDLE : SB_DRAIN;
         end
         SB_DRAIN: begin
            FromStoreBuffer = 1'b1;
            W_Enable        = 1'b1;
            SB_Pop          = 1'b1;
            if (En) begin
               if (RW || same_line || C_Miss) Stall    = 1'b1;
               else                           R_Enable = 1'b1;
            end
            if (SB_Count <= CW'(1)) state_d = IDLE;
         end
         WT_WAIT: begin
            Stall = !WT_Done;
            if (WT_Done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= IDLE;
         lf_addr_q  <= '0;
         lw_pend_q  <= 1'b0;
         lf_done_q  <= 1'b0;
         lf_start_q <= 1'b0;
         lw_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lf_start_q <= start_miss;
         lw_start_q <= start_miss && C_Dirty;
         if (start_miss) begin
            lf_addr_q <= req_line;
            lw_pend_q <= C_Dirty;
            lf_done_q <= 1'b0;
         end else begin
            if (LW_Done) lw_pend_q <= 1'b0;
            if (LF_Done && (state_q == MISS_CRIT || state_q == MISS_REST)) lf_done_q <= 1'b1;
            else if (state_q == LINE_WR)                                    lf_done_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cache_ctrl_nb.sv
// tb/tb_cache_ctrl_nb.sv - directed self-checking bench for cache_ctrl_nb
module tb_cache_ctrl_nb;

   logic        Clk, Rst_n;
   logic        En, RW, C_Miss, C_Dirty, LF_FirstWord, LF_Done, LW_Done, WT_Done;
   logic [31:0] WordAddress;

   logic        wb_Stall, wb_R_Enable, wb_W_Enable, wb_WriteType, wb_Merge, wb_FromStoreBuffer;
   logic        wb_CrtWord, wb_LF_Start, wb_LW_Start, wb_WT_Start, wb_SB_Push, wb_SB_Pop;
   logic [31:0] wb_LF_LineAddr;
   logic [2:0]  wb_SB_Count;

   logic        wt_Stall, wt_R_Enable, wt_W_Enable, wt_WriteType, wt_Merge, wt_FromStoreBuffer;
   logic        wt_CrtWord, wt_LF_Start, wt_LW_Start, wt_WT_Start, wt_SB_Push, wt_SB_Pop;
   logic [31:0] wt_LF_LineAddr;
   logic [2:0]  wt_SB_Count;

   int vecs = 0;
   int errs = 0;

   cache_ctrl_nb #(.WT_MODE(1'b0)) u_wb (
      .Clk(Clk), .Rst_n(Rst_n), .En(En), .RW(RW), .WordAddress(WordAddress),
      .Stall(wb_Stall), .C_Miss(C_Miss), .C_Dirty(C_Dirty), .R_Enable(wb_R_Enable),
      .W_Enable(wb_W_Enable), .WriteType(wb_WriteType), .Merge(wb_Merge),
      .FromStoreBuffer(wb_FromStoreBuffer), .CrtWord(wb_CrtWord), .LF_Start(wb_LF_Start),
      .LF_LineAddr(wb_LF_LineAddr), .LF_FirstWord(LF_FirstWord), .LF_Done(LF_Done),
      .LW_Start(wb_LW_Start), .LW_Done(LW_Done), .WT_Start(wb_WT_Start), .WT_Done(WT_Done),
      .SB_Push(wb_SB_Push), .SB_Pop(wb_SB_Pop), .SB_Count(wb_SB_Count)
   );

   cache_ctrl_nb #(.WT_MODE(1'b1)) u_wt (
      .Clk(Clk), .Rst_n(Rst_n), .En(En), .RW(RW), .WordAddress(WordAddress),
      .Stall(wt_Stall), .C_Miss(C_Miss), .C_Dirty(C_Dirty), .R_Enable(wt_R_Enable),
      .W_Enable(wt_W_Enable), .WriteType(wt_WriteType), .Merge(wt_Merge),
      .FromStoreBuffer(wt_FromStoreBuffer), .CrtWord(wt_CrtWord), .LF_Start(wt_LF_Start),
      .LF_LineAddr(wt_LF_LineAddr), .LF_FirstWord(LF_FirstWord), .LF_Done(LF_Done),
      .LW_Start(wt_LW_Start), .LW_Done(LW_Done), .WT_Start(wt_WT_Start), .WT_Done(WT_Done),
      .SB_Push(wt_SB_Push), .SB_Pop(wt_SB_Pop), .SB_Count(wt_SB_Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_in();
      En = 1'b0; RW = 1'b0; WordAddress = 32'h0; C_Miss = 1'b0; C_Dirty = 1'b0;
      LF_FirstWord = 1'b0; LF_Done = 1'b0; LW_Done = 1'b0; WT_Done = 1'b0;
   endtask

   task automatic reset_pulse();
      Rst_n = 1'b0;
      tick();
      Rst_n = 1'b1;
   endtask

   initial begin
      Rst_n = 1'b0;
      idle_in();
      #1;
      chk("rst_stall", 32'(wb_Stall), 32'd0);
      chk("rst_lf_start", 32'(wb_LF_Start), 32'd0);
      chk("rst_sb_count", 32'(wb_SB_Count), 32'd0);
      chk("rst_lf_addr", wb_LF_LineAddr, 32'h0);
      tick();
      Rst_n = 1'b1;
      tick();

      // 1: read hit
      En = 1'b1; RW = 1'b0; WordAddress = 32'h0000_0040; C_Miss = 1'b0;
      #2;
      chk("t1_r_enable", 32'(wb_R_Enable), 32'd1);
      chk("t1_stall", 32'(wb_Stall), 32'd0);
      chk("t1_lf_start", 32'(wb_LF_Start), 32'd0);
      tick();

      // 2: clean read miss
      WordAddress = 32'h0000_0123; C_Miss = 1'b1; C_Dirty = 1'b0;
      #2;
      chk("t2_idle_stall", 32'(wb_Stall), 32'd1);
      tick();
      #2;
      chk("t2_lf_start", 32'(wb_LF_Start), 32'd1);
      chk("t2_lf_addr", wb_LF_LineAddr, 32'h0000_0120);
      chk("t2_lw_start", 32'(wb_LW_Start), 32'd0);
      chk("t2_crit_stall", 32'(wb_Stall), 32'd1);
      tick();
      #2;
      chk("t2_lf_start_off", 32'(wb_LF_Start), 32'd0);
      chk("t2_wait_stall", 32'(wb_Stall), 32'd1);
      LF_FirstWord = 1'b1;
      #1;
      chk("t2_crtword", 32'(wb_CrtWord), 32'd1);
      chk("t2_crt_stall", 32'(wb_Stall), 32'd0);
      tick();
      idle_in();
      LF_Done = 1'b1;
      #2;
      chk("t2_rest_wt", 32'(wb_WriteType), 32'd0);
      tick();
      LF_Done = 1'b0;
      tick();
      #2;
      chk("t2_line_wt", 32'(wb_WriteType), 32'd1);
      chk("t2_line_we", 32'(wb_W_Enable), 32'd1);
      chk("t2_line_merge", 32'(wb_Merge), 32'd0);
      chk("t2_line_stall", 32'(wb_Stall), 32'd1);
      tick();
      #2;
      chk("t2_idle_wt", 32'(wb_WriteType), 32'd0);
      chk("t2_idle_pop", 32'(wb_SB_Pop), 32'd0);

      // 3: dirty read miss, LW_Done three cycles after LF_Done
      En = 1'b1; RW = 1'b0; WordAddress = 32'h0000_0205; C_Miss = 1'b1; C_Dirty = 1'b1;
      tick();
      C_Dirty = 1'b0;
      #2;
      chk("t3_lf_start", 32'(wb_LF_Start), 32'd1);
      chk("t3_lw_start", 32'(wb_LW_Start), 32'd1);
      chk("t3_lf_addr", wb_LF_LineAddr, 32'h0000_0200);
      LF_FirstWord = 1'b1;
      #1;
      chk("t3_crtword", 32'(wb_CrtWord), 32'd1);
      tick();
      idle_in();
      LF_Done = 1'b1;
      #2;
      chk("t3_lw_start_off", 32'(wb_LW_Start), 32'd0);
      tick();
      LF_Done = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         LW_Done = (i == 3);
         #2;
         chk($sformatf("t3_wait%0d_wt", i), 32'(wb_WriteType), 32'd0);
         tick();
      end
      LW_Done = 1'b0;
      #2;
      chk("t3_line_wt", 32'(wb_WriteType), 32'd1);
      tick();

      // 4: stores to the fill line queue in the SB, fifth stalls until drained
      En = 1'b1; RW = 1'b0; WordAddress = 32'h0000_0300; C_Miss = 1'b1;
      tick();
      LF_FirstWord = 1'b1;
      #2;
      chk("t4_crtword", 32'(wb_CrtWord), 32'd1);
      tick();
      LF_FirstWord = 1'b0;
      RW = 1'b1;
      for (int i = 0; i < 4; i++) begin
         WordAddress = 32'h0000_0300 + 32'(i);
         #2;
         chk($sformatf("t4_push%0d", i), 32'(wb_SB_Push), 32'd1);
         chk($sformatf("t4_push%0d_stall", i), 32'(wb_Stall), 32'd0);
         tick();
         chk($sformatf("t4_count%0d", i), 32'(wb_SB_Count), 32'(i + 1));
      end
      WordAddress = 32'h0000_0304;
      LF_Done = 1'b1;
      #2;
      chk("t4_full_stall", 32'(wb_Stall), 32'd1);
      chk("t4_full_push", 32'(wb_SB_Push), 32'd0);
      tick();
      LF_Done = 1'b0;
      #2;
      chk("t4_count_hold", 32'(wb_SB_Count), 32'd4);
      tick();
      #2;
      chk("t4_line_wt", 32'(wb_WriteType), 32'd1);
      chk("t4_line_merge", 32'(wb_Merge), 32'd1);
      tick();
      for (int i = 0; i < 4; i++) begin
         #2;
         chk($sformatf("t4_pop%0d", i), 32'(wb_SB_Pop), 32'd1);
         chk($sformatf("t4_fsb%0d", i), 32'(wb_FromStoreBuffer), 32'd1);
         chk($sformatf("t4_drain_stall%0d", i), 32'(wb_Stall), 32'd1);
         chk($sformatf("t4_drain_cnt%0d", i), 32'(wb_SB_Count), 32'(4 - i));
         tick();
      end
      C_Miss = 1'b0;
      #2;
      chk("t4_count_zero", 32'(wb_SB_Count), 32'd0);
      chk("t4_fifth_we", 32'(wb_W_Enable), 32'd1);
      chk("t4_fifth_stall", 32'(wb_Stall), 32'd0);
      chk("t4_fifth_fsb", 32'(wb_FromStoreBuffer), 32'd0);
      tick();
      idle_in();
      reset_pulse();

      // 5: write-through write miss
      En = 1'b1; RW = 1'b1; WordAddress = 32'h0000_0500; C_Miss = 1'b1;
      #2;
      chk("t5_wt_start", 32'(wt_WT_Start), 32'd1);
      chk("t5_stall", 32'(wt_Stall), 32'd1);
      chk("t5_no_we", 32'(wt_W_Enable), 32'd0);
      tick();
      #2;
      chk("t5_wt_start_off", 32'(wt_WT_Start), 32'd0);
      chk("t5_no_lf_start", 32'(wt_LF_Start), 32'd0);
      chk("t5_wait_stall", 32'(wt_Stall), 32'd1);
      tick();
      WT_Done = 1'b1;
      #2;
      chk("t5_done_stall", 32'(wt_Stall), 32'd0);
      tick();
      idle_in();
      #2;
      chk("t5_idle_wt_start", 32'(wt_WT_Start), 32'd0);
      reset_pulse();

      // 6: asynchronous reset during MISS_REST
      En = 1'b1; RW = 1'b0; WordAddress = 32'h0000_0600; C_Miss = 1'b1; C_Dirty = 1'b1;
      tick();
      C_Dirty = 1'b0;
      LF_FirstWord = 1'b1;
      tick();
      LF_FirstWord = 1'b0;
      RW = 1'b1; WordAddress = 32'h0000_0601;
      tick();
      En = 1'b0;
      #1;
      chk("t6_pre_count", 32'(wb_SB_Count), 32'd1);
      chk("t6_pre_addr", wb_LF_LineAddr, 32'h0000_0600);
      Rst_n = 1'b0;
      #1;
      chk("t6_rst_count", 32'(wb_SB_Count), 32'd0);
      chk("t6_rst_addr", wb_LF_LineAddr, 32'h0);
      chk("t6_rst_stall", 32'(wb_Stall), 32'd0);
      chk("t6_rst_lw_start", 32'(wb_LW_Start), 32'd0);
      tick();
      Rst_n = 1'b1;
      En = 1'b1; RW = 1'b0; WordAddress = 32'h0000_0040; C_Miss = 1'b0;
      #2;
      chk("t6_idle_r_enable", 32'(wb_R_Enable), 32'd1);
      chk("t6_idle_stall", 32'(wb_Stall), 32'd0);
      tick();
      idle_in();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
